branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data/address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: statistics counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ex_valid  input  1  EX stage holds a valid instruction.
REQ-006 SHALL have port ex_branch  input  1  conditional branch in EX.
REQ-007 SHALL have port ex_jal  input  1  JAL in EX.
REQ-008 SHALL have port ex_jalr  input  1  JALR in EX.
REQ-009 SHALL have port ex_funct3  input  3  branch condition code.
REQ-010 SHALL have ports zero, negative, carry, overflow  input  1 each  ALU flags from the A-B subtraction of the EX instruction.
REQ-011 SHALL have port ex_pc  input  WIDTH  PC of the EX instruction.
REQ-012 SHALL have port ex_imm  input  WIDTH  sign-extended offset.
REQ-013 SHALL have port alu_result  input  WIDTH  rs1+imm, used for the JALR target.
REQ-014 SHALL have port fetch_ready  input  1  fetch accepts a redirect.
REQ-015 SHALL have port redirect_valid  output  1  redirect request.
REQ-016 SHALL have port redirect_pc  output  WIDTH  redirect target.
REQ-017 SHALL have ports flush_if_id, flush_id_ex  output  1 each  one-cycle pipeline flush pulses.
REQ-018 SHALL have port stall_ex  output  1  holds EX while a redirect is pending.
REQ-019 SHALL have port misalign_err  output  1  one-cycle pulse on a misaligned target.
REQ-020 SHALL have ports branch_cnt, taken_cnt  output  CNT_WIDTH each  resolved conditional branches; issued redirects.

Function
REQ-021 SHALL evaluate the condition from ex_funct3: 000 beq=zero; 001 bne=~zero; 100 blt=negative^overflow; 101 bge=~(negative^overflow); 110 bltu=~carry; 111 bgeu=carry; 010/011 = not taken.
REQ-022 SHALL set taken = ex_valid & (ex_jal | ex_jalr | (ex_branch & cond)).
REQ-023 SHALL compute the target as ex_pc+ex_imm (modulo 2^WIDTH) for branch/JAL and as alu_result with bit 0 cleared for JALR.
REQ-024 SHALL implement FSM states IDLE and REDIRECT.
REQ-025 SHALL, in IDLE with taken and target[1:0]==00, latch the target and enter REDIRECT at the next edge.
REQ-026 SHALL, on entering REDIRECT, assert flush_if_id and flush_id_ex for exactly one cycle.
REQ-027 SHALL hold redirect_valid=1 and redirect_pc stable throughout REDIRECT.
REQ-028 SHALL complete the transfer on a cycle with redirect_valid & fetch_ready, then return to IDLE at the next edge.
REQ-029 SHALL drive stall_ex = (state==REDIRECT) & ~fetch_ready.
REQ-030 SHALL ignore ex_valid and all EX inputs while in REDIRECT.
REQ-031 SHALL, in IDLE with taken and target[1:0]!=00, pulse misalign_err for one cycle, stay in IDLE, issue no redirect and no flush.
REQ-032 SHALL, when more than one of ex_branch, ex_jal and ex_jalr is set, give priority jalr > jal > branch.
REQ-033 SHALL increment branch_cnt once per IDLE cycle with ex_valid & ex_branch, whether taken or not.
REQ-034 SHALL increment taken_cnt once per REDIRECT entry.
REQ-035 SHALL let both counters wrap from all-ones to 0.

Reset
REQ-036 SHALL, on rst_n low, immediately force state IDLE and redirect_valid=0, redirect_pc=0, flush_if_id=0, flush_id_ex=0, stall_ex=0, misalign_err=0, branch_cnt=0, taken_cnt=0.
REQ-037 SHALL abandon any pending redirect on reset mid-REDIRECT, with no completion after release.
REQ-038 SHALL take its first possible redirect entry at the first clock edge after rst_n rises.

Structure
REQ-039 SHALL take the funct3 encodings and the FSM state encoding from the shared core package.
REQ-040 SHALL place condition evaluation in one combinational sub-module, branch_cond (inputs: funct3 and flags; output: cond).

Verification
REQ-041 SHALL cover: beq with zero=1, ex_pc=0x100, imm=0x20 -> redirect_pc=0x120 next cycle, one-cycle flushes, taken_cnt=1.
REQ-042 SHALL cover: blt with negative=1, overflow=1 -> not taken, no redirect, branch_cnt increments, taken_cnt unchanged.
REQ-043 SHALL cover: JALR with alu_result=0x2001 -> redirect_pc=0x2000; with alu_result=0x2002 -> misalign_err pulse, no redirect.
REQ-044 SHALL cover: redirect issued with fetch_ready low for 3 cycles -> redirect_valid, redirect_pc and stall_ex held 3 cycles; IDLE one cycle after the handshake.
REQ-045 SHALL cover: rst_n pulsed low while in REDIRECT -> outputs 0 asynchronously; no redirect after release.
REQ-046 SHALL cover: branch_cnt preloaded by 0xFFFF branches, then one more branch -> branch_cnt=0x0000.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared core definitions for branch resolution:
// funct3 branch encodings and the redirect FSM states.
package branch_resolve_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_resolve_cond.sv
// Branch condition evaluation from funct3 and the
// flags of the EX-stage A-B subtraction.
module branch_cond
    import branch_resolve_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry,
    input  logic       overflow,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = ~zero;
            F3_BLT:  cond = negative ^ overflow;
            F3_BGE:  cond = ~(negative ^ overflow);
            // carry set means no borrow, i.e. A >= B unsigned
            F3_BLTU: cond = ~carry;
            F3_BGEU: cond = carry;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: decides taken, computes the
// target and hands a redirect to fetch with pipeline flushes.
module branch_resolve #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic                 ex_branch,
    input  logic                 ex_jal,
    input  logic                 ex_jalr,
    input  logic [2:0]           ex_funct3,
    input  logic                 zero,
    input  logic                 negative,
    input  logic                 carry,
    input  logic                 overflow,
    input  logic [WIDTH-1:0]     ex_pc,
    input  logic [WIDTH-1:0]     ex_imm,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 fetch_ready,
    output logic                 redirect_valid,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 stall_ex,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    import branch_resolve_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    br_state_e            state_q;
    logic                 rvalid_q;
    logic [WIDTH-1:0]     rpc_q;
    logic                 flush_q;
    logic                 misalign_q;
    logic [CNT_WIDTH-1:0] bcnt_q;
    logic [CNT_WIDTH-1:0] tcnt_q;

    logic             cond;
    logic             taken;
    logic [WIDTH-1:0] target;
    logic             aligned;

    branch_cond u_cond (
        .funct3   (ex_funct3),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow),
        .cond     (cond)
    );

    assign taken = ex_valid &
                   (ex_jal | ex_jalr | (ex_branch & cond));

    // JALR wins over JAL/branch; the latter two share pc+imm
    always_comb begin
        target = ex_pc + ex_imm;
        if (ex_jalr)
            target = {alu_result[WIDTH-1:1], 1'b0};
    end

    assign aligned = (target[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rvalid_q   <= 1'b0;
            rpc_q      <= '0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
        end else begin
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ex_valid && ex_branch)
                        bcnt_q <= bcnt_q + CNT_ONE;
                    if (taken && aligned) begin
                        state_q  <= S_REDIRECT;
                        rvalid_q <= 1'b1;
                        rpc_q    <= target;
                        flush_q  <= 1'b1;
                        tcnt_q   <= tcnt_q + CNT_ONE;
                    end else if (taken) begin
                        misalign_q <= 1'b1;
                    end
                end
                S_REDIRECT: begin
                    if (fetch_ready) begin
                        state_q  <= S_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = rvalid_q;
    assign redirect_pc    = rpc_q;
    assign flush_if_id    = flush_q;
    assign flush_id_ex    = flush_q;
    assign misalign_err   = misalign_q;
    assign branch_cnt     = bcnt_q;
    assign taken_cnt      = tcnt_q;
    assign stall_ex       = (state_q == S_REDIRECT) & ~fetch_ready;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: redirects, flushes,
// misalignment, backpressure, async reset and counter wrap.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_branch, ex_jal, ex_jalr;
    logic [2:0]  ex_funct3;
    logic        zero, negative, carry, overflow;
    logic [31:0] ex_pc, ex_imm, alu_result;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id, flush_id_ex, stall_ex, misalign_err;
    logic [15:0] branch_cnt, taken_cnt;

    int checks = 0;
    int errors = 0;

    branch_resolve dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_jal         (ex_jal),
        .ex_jalr        (ex_jalr),
        .ex_funct3      (ex_funct3),
        .zero           (zero),
        .negative       (negative),
        .carry          (carry),
        .overflow       (overflow),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .alu_result     (alu_result),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .stall_ex       (stall_ex),
        .misalign_err   (misalign_err),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ex_valid   = 1'b0;
        ex_branch  = 1'b0;
        ex_jal     = 1'b0;
        ex_jalr    = 1'b0;
        ex_funct3  = 3'b000;
        zero       = 1'b0;
        negative   = 1'b0;
        carry      = 1'b0;
        overflow   = 1'b0;
        ex_pc      = 32'h0;
        ex_imm     = 32'h0;
        alu_result = 32'h0;
    endtask

    // idle outputs with given counters
    task automatic chk_idle(input string tag, input logic [15:0] bc,
                            input logic [15:0] tc);
        chk({tag, "_rv"}, {31'b0, redirect_valid}, 32'h0);
        chk({tag, "_fl"}, {30'b0, flush_if_id, flush_id_ex}, 32'h0);
        chk({tag, "_st"}, {31'b0, stall_ex}, 32'h0);
        chk({tag, "_bc"}, {16'b0, branch_cnt}, {16'b0, bc});
        chk({tag, "_tc"}, {16'b0, taken_cnt}, {16'b0, tc});
    endtask

    initial begin
        clr();
        fetch_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        chk_idle("reset", 16'h0, 16'h0);
        chk("reset_pc", redirect_pc, 32'h0);
        chk("reset_mis", {31'b0, misalign_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // beq taken right after reset release
        ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b000; zero = 1;
        ex_pc = 32'h100; ex_imm = 32'h20;
        tick();
        clr();
        chk("beq_rv", {31'b0, redirect_valid}, 32'h1);
        chk("beq_pc", redirect_pc, 32'h120);
        chk("beq_fl", {30'b0, flush_if_id, flush_id_ex}, 32'h3);
        chk("beq_st", {31'b0, stall_ex}, 32'h0);
        chk("beq_tc", {16'b0, taken_cnt}, 32'h1);
        chk("beq_bc", {16'b0, branch_cnt}, 32'h1);
        tick();
        chk_idle("beq_done", 16'h1, 16'h1);

        // blt with N^V = 0 is not taken
        ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b100;
        negative = 1; overflow = 1; ex_pc = 32'h200; ex_imm = 32'h40;
        tick();
        clr();
        chk_idle("blt_nt", 16'h2, 16'h1);
        chk("blt_mis", {31'b0, misalign_err}, 32'h0);

        // jalr clears bit 0
        ex_valid = 1; ex_jalr = 1; alu_result = 32'h2001;
        tick();
        clr();
        chk("jalr_rv", {31'b0, redirect_valid}, 32'h1);
        chk("jalr_pc", redirect_pc, 32'h2000);
        chk("jalr_tc", {16'b0, taken_cnt}, 32'h2);
        tick();
        chk_idle("jalr_done", 16'h2, 16'h2);

        // jalr to 0x2002 is misaligned
        ex_valid = 1; ex_jalr = 1; alu_result = 32'h2002;
        tick();
        clr();
        chk("mis_pulse", {31'b0, misalign_err}, 32'h1);
        chk_idle("mis", 16'h2, 16'h2);
        tick();
        chk("mis_clear", {31'b0, misalign_err}, 32'h0);
        chk("mis_rv2", {31'b0, redirect_valid}, 32'h0);

        // jal+jalr together: jalr target wins
        ex_valid = 1; ex_jal = 1; ex_jalr = 1;
        ex_pc = 32'h300; ex_imm = 32'h10; alu_result = 32'h500;
        tick();
        clr();
        chk("prio_pc", redirect_pc, 32'h500);
        chk("prio_tc", {16'b0, taken_cnt}, 32'h3);
        tick();

        // bltu with carry=0 taken, negative offset wraps
        ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b110; carry = 0;
        ex_pc = 32'h400; ex_imm = 32'hFFFF_FFFC;
        tick();
        clr();
        chk("bltu_pc", redirect_pc, 32'h3FC);
        chk("bltu_bc", {16'b0, branch_cnt}, 32'h3);
        chk("bltu_tc", {16'b0, taken_cnt}, 32'h4);
        tick();

        // fetch backpressure for 3 cycles, EX noise ignored
        fetch_ready = 0;
        ex_valid = 1; ex_jal = 1; ex_pc = 32'h1000; ex_imm = 32'h8;
        tick();
        ex_branch = 1; ex_imm = 32'h80; ex_pc = 32'h7000;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_rv", i), {31'b0, redirect_valid}, 32'h1);
            chk($sformatf("bp%0d_pc", i), redirect_pc, 32'h1008);
            chk($sformatf("bp%0d_st", i), {31'b0, stall_ex}, 32'h1);
            chk($sformatf("bp%0d_fl", i), {31'b0, flush_if_id},
                (i == 0) ? 32'h1 : 32'h0);
            chk($sformatf("bp%0d_tc", i), {16'b0, taken_cnt}, 32'h5);
            chk($sformatf("bp%0d_bc", i), {16'b0, branch_cnt}, 32'h3);
            if (i < 2) tick();
        end
        fetch_ready = 1;
        #1;
        chk("bp_hs_st", {31'b0, stall_ex}, 32'h0);
        chk("bp_hs_rv", {31'b0, redirect_valid}, 32'h1);
        tick();
        clr();
        chk_idle("bp_done", 16'h3, 16'h5);

        // async reset while in REDIRECT
        fetch_ready = 0;
        ex_valid = 1; ex_jal = 1; ex_pc = 32'h2000; ex_imm = 32'h4;
        tick();
        clr();
        chk("rst_pre_rv", {31'b0, redirect_valid}, 32'h1);
        #2;
        rst_n = 0;
        #1;
        chk_idle("rst_async", 16'h0, 16'h0);
        chk("rst_async_pc", redirect_pc, 32'h0);
        fetch_ready = 1;
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("rst_post_rv", {31'b0, redirect_valid}, 32'h0);
        chk("rst_post_tc", {16'b0, taken_cnt}, 32'h0);
        tick();
        chk("rst_post_rv2", {31'b0, redirect_valid}, 32'h0);

        // counter wrap with not-taken branches
        ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b010; zero = 1;
        repeat (16'hFFFF) tick();
        chk("wrap_full", {16'b0, branch_cnt}, 32'hFFFF);
        tick();
        clr();
        chk("wrap_zero", {16'b0, branch_cnt}, 32'h0);
        chk("wrap_tc", {16'b0, taken_cnt}, 32'h0);
        chk("wrap_rv", {31'b0, redirect_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
